// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and default constants for the UART transmit scheduler.
//   sched_state_t       : scheduler FSM state encoding
//   DEFAULT_SIZE        : default byte width in bits
//   DEFAULT_NUM_REQ     : default number of requesters
//   DEFAULT_WDOG_CYCLES : default watchdog limit in clk cycles
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } sched_state_t;

    localparam int DEFAULT_SIZE        = 8;
    localparam int DEFAULT_NUM_REQ     = 4;
    localparam int DEFAULT_WDOG_CYCLES = 4096;

endpackage : uart_pkg

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: scans req starting at 'pointer', wrapping
// modulo NUM_REQ, and returns the first set bit.
// Ports:
//   req     in  NUM_REQ  request vector
//   pointer in  IDX_W    index where the search starts
//   valid   out 1        at least one request is set
//   index   out IDX_W    winning requester index (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    // NOTE: every output gets a default before the loop so no path through the
    // block leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[(int'(pointer) + i) % NUM_REQ]) begin
                valid = 1'b1;
                index = IDX_W'((int'(pointer) + i) % NUM_REQ);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter between NUM_REQ requesters. A round-robin winner
// is latched in IDLE, strobed to the transmitter in LAUNCH, and the FSM then
// follows tx_busy high (WAIT_START) and low again (WAIT_DONE) before the next
// grant. Optional watchdog: define UART_SCHED_WDOG_EN to abort a transfer whose
// transmitter handshake stalls for WDOG_CYCLES clocks; wdog_err is sticky.
// Ports:
//   clk        in  1               system clock
//   rst        in  1               synchronous active-high reset
//   req        in  NUM_REQ         per-requester send request (level)
//   req_data   in  NUM_REQ*SIZE    byte of requester i at [i*SIZE +: SIZE]
//   ack        out NUM_REQ         one-cycle accept pulse
//   tx_busy    in  1               transmitter busy flag
//   tx_en      out 1               one-cycle transmit strobe
//   data_in    out SIZE            byte presented to the transmitter
//   grant_id   out $clog2(NUM_REQ) current/last granted requester
//   sched_busy out 1               high in every state except IDLE
//   wdog_err   out 1               sticky watchdog error (0 without the macro)
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int SIZE        = DEFAULT_SIZE,
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int WDOG_CYCLES = DEFAULT_WDOG_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*SIZE-1:0]    req_data,
    output logic [NUM_REQ-1:0]         ack,
    input  logic                       tx_busy,
    output logic                       tx_en,
    output logic [SIZE-1:0]            data_in,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       sched_busy,
    output logic                       wdog_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2) begin : g_num_req_check
        $error("uart_tx_scheduler: NUM_REQ must be at least 2");
    end
    if (WDOG_CYCLES < 1) begin : g_wdog_check
        $error("uart_tx_scheduler: WDOG_CYCLES must be at least 1");
    end

    sched_state_t     state;
    logic [IDX_W-1:0] rr_ptr;     // where the next search starts
    logic             arb_valid;
    logic [IDX_W-1:0] arb_index;
    logic [IDX_W-1:0] next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req),
        .pointer (rr_ptr),
        .valid   (arb_valid),
        .index   (arb_index)
    );

    assign next_ptr = (arb_index == IDX_W'(NUM_REQ - 1)) ? '0 : arb_index + 1'b1;

`ifdef UART_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_hit;

    // Counter is cleared on entering WAIT_START/WAIT_DONE, so it measures
    // time spent in the current wait state only.
    assign wdog_hit = (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
    assign wdog_err = 1'b0;
`endif

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every branch reads pre-edge values and the block maps to plain flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            tx_en      <= 1'b0;
            ack        <= '0;
            data_in    <= '0;
            grant_id   <= '0;
            sched_busy <= 1'b0;
`ifdef UART_SCHED_WDOG_EN
            wdog_cnt   <= '0;
            wdog_err   <= 1'b0;
`endif
        end else begin
            // tx_en and ack are pulses: only the IDLE->LAUNCH edge raises them.
            tx_en <= 1'b0;
            ack   <= '0;

            case (state)
                IDLE: begin
                    // A busy transmitter blocks the grant and freezes rr_ptr.
                    if (arb_valid && !tx_busy) begin
                        state      <= LAUNCH;
                        grant_id   <= arb_index;
                        data_in    <= req_data[arb_index*SIZE +: SIZE];
                        rr_ptr     <= next_ptr;
                        tx_en      <= 1'b1;
                        ack        <= NUM_REQ'(1) << arb_index;
                        sched_busy <= 1'b1;
                    end
                end

                LAUNCH: begin
                    state <= WAIT_START;
`ifdef UART_SCHED_WDOG_EN
                    wdog_cnt <= '0;
`endif
                end

                WAIT_START: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
`ifdef UART_SCHED_WDOG_EN
                        wdog_cnt <= '0;
                    end else if (wdog_hit) begin
                        state      <= IDLE;
                        sched_busy <= 1'b0;
                        wdog_err   <= 1'b1;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
`endif
                    end
                end

                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state      <= IDLE;
                        sched_busy <= 1'b0;
`ifdef UART_SCHED_WDOG_EN
                    end else if (wdog_hit) begin
                        state      <= IDLE;
                        sched_busy <= 1'b0;
                        wdog_err   <= 1'b1;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
`endif
                    end
                end

                default: begin
                    state      <= IDLE;
                    sched_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule : uart_tx_scheduler

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Scoreboard bench: the stimulus process pushes the expected grant (requester
// index and byte) into a queue; a monitor pops and compares on every tx_en/ack.
// A small transmitter model raises tx_busy one cycle after tx_en for a
// programmable number of cycles. Watchdog expectations follow
// UART_SCHED_WDOG_EN with WDOG_CYCLES=16.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int SIZE        = 8;
    localparam int NUM_REQ     = 4;
    localparam int WDOG_CYCLES = 16;

    typedef struct {
        int              id;
        logic [SIZE-1:0] data;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ*SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]      ack;
    logic                    tx_busy;
    logic                    tx_en;
    logic [SIZE-1:0]         data_in;
    logic [1:0]              grant_id;
    logic                    sched_busy;
    logic                    wdog_err;

    // Transmitter model and direct busy override
    logic model_en;
    logic model_busy;
    int   model_len;
    int   model_cnt;
    logic force_busy;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tx_cnt   = 0;
    int   ack_seen = 0;
    int   ack_per[NUM_REQ];

    assign tx_busy = model_en ? model_busy : force_busy;

    uart_tx_scheduler #(
        .SIZE        (SIZE),
        .NUM_REQ     (NUM_REQ),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .tx_busy    (tx_busy),
        .tx_en      (tx_en),
        .data_in    (data_in),
        .grant_id   (grant_id),
        .sched_busy (sched_busy),
        .wdog_err   (wdog_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Transmitter model: busy from the cycle after tx_en for model_len cycles.
    always @(posedge clk) begin
        if (rst) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (model_en && tx_en) begin
            model_busy <= 1'b1;
            model_cnt  <= model_len - 1;
        end else if (model_cnt > 0) begin
            model_cnt <= model_cnt - 1;
        end else begin
            model_busy <= 1'b0;
        end
    end

    // Monitor: every tx_en/ack must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (tx_en || ack != '0)) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: got grant_id %0d ack 0x%0h, expected no grant",
                         grant_id, ack);
            end else begin
                e = sb_q.pop_front();
                check("sb_tx_en",    32'(tx_en),    32'd1);
                check("sb_ack",      32'(ack),      32'd1 << e.id);
                check("sb_grant_id", 32'(grant_id), 32'(e.id));
                check("sb_data_in",  32'(data_in),  32'(e.data));
            end
            if (tx_en) tx_cnt++;
            if (ack != '0) ack_seen++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack[i]) ack_per[i]++;
            end
        end
    end

    task automatic push_exp(input int id, input logic [SIZE-1:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (sched_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(!sched_busy), 32'd1);
    endtask

    task automatic wait_acks(input int target, input int budget, input string name);
        int n = 0;
        while (ack_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(ack_seen >= target), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_en"},      32'(tx_en),      32'd0);
        check({tag, "_ack"},        32'(ack),        32'd0);
        check({tag, "_data_in"},    32'(data_in),    32'd0);
        check({tag, "_grant_id"},   32'(grant_id),   32'd0);
        check({tag, "_sched_busy"}, 32'(sched_busy), 32'd0);
        check({tag, "_wdog_err"},   32'(wdog_err),   32'd0);
    endtask

    initial begin : global_timeout
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int base_tx;
        int base_ack;
        int base_per[NUM_REQ];

        for (int i = 0; i < NUM_REQ; i++) ack_per[i] = 0;
        rst        = 1'b1;
        req        = '0;
        req_data   = '0;
        model_en   = 1'b1;
        model_len  = 87;
        force_busy = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single byte from requester 0, one-cycle grant latency
        base_tx = tx_cnt;
        req_data[0*SIZE +: SIZE] = 8'hA5;
        push_exp(0, 8'hA5);
        req = 4'b0001;
        @(negedge clk);
        check("single_latency_tx_en", 32'(tx_en), 32'd1);
        req = 4'b0000;
        repeat (20) @(negedge clk);
        check("single_busy_mid", 32'(sched_busy), 32'd1);
        check("single_tx_en_low", 32'(tx_en), 32'd0);
        wait_idle(200, "single_idle_timeout");
        check("single_tx_count", 32'(tx_cnt - base_tx), 32'd1);
        check("single_hold_data", 32'(data_in), 32'hA5);
        check("single_hold_grant", 32'(grant_id), 32'd0);

        // Fairness from reset: order 0,1,2,3,0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_len = 5;
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        for (int i = 0; i < NUM_REQ; i++) base_per[i] = ack_per[i];
        base_ack = ack_seen;
        push_exp(0, 8'h10);
        push_exp(1, 8'h21);
        push_exp(2, 8'h32);
        push_exp(3, 8'h43);
        push_exp(0, 8'h10);
        req = 4'b1111;
        wait_acks(base_ack + 5, 200, "fair_ack_timeout");
        req = 4'b0000;
        wait_idle(50, "fair_idle_timeout");
        check("fair_acks_r0", 32'(ack_per[0] - base_per[0]), 32'd2);
        check("fair_acks_r1", 32'(ack_per[1] - base_per[1]), 32'd1);
        check("fair_acks_r2", 32'(ack_per[2] - base_per[2]), 32'd1);
        check("fair_acks_r3", 32'(ack_per[3] - base_per[3]), 32'd1);

        // Busy transmitter blocks the grant; release grants next cycle
        model_en   = 1'b0;
        force_busy = 1'b1;
        base_tx    = tx_cnt;
        req_data[1*SIZE +: SIZE] = 8'h3C;
        req = 4'b0010;
        repeat (10) @(negedge clk);
        check("block_no_tx", 32'(tx_cnt - base_tx), 32'd0);
        check("block_idle", 32'(sched_busy), 32'd0);
        push_exp(1, 8'h3C);
        force_busy = 1'b0;
        @(negedge clk);
        check("block_release_tx_en", 32'(tx_en), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        force_busy = 1'b1;
        repeat (3) @(negedge clk);
        force_busy = 1'b0;
        wait_idle(20, "block_idle_timeout");

        // Reset in WAIT_DONE abandons the transfer; held req is regranted
        model_en  = 1'b1;
        model_len = 87;
        req_data[0*SIZE +: SIZE] = 8'h5A;
        base_ack = ack_seen;
        push_exp(0, 8'h5A);
        req = 4'b0001;
        wait_acks(base_ack + 1, 20, "rstmid_ack_timeout");
        repeat (10) @(negedge clk);
        check("rstmid_busy_before", 32'(sched_busy), 32'd1);
        base_ack = ack_seen;
        push_exp(0, 8'h5A);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rstmid");
        check("rstmid_no_ack", 32'(ack_seen), 32'(base_ack));
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_regrant_tx_en", 32'(tx_en), 32'd1);
        req = 4'b0000;
        wait_idle(200, "rstmid_idle_timeout");

        // Watchdog: transmitter never goes busy
        model_en   = 1'b0;
        force_busy = 1'b0;
        req_data[2*SIZE +: SIZE] = 8'h77;
        push_exp(2, 8'h77);
        req = 4'b0100;
        @(negedge clk);
        check("wdog_tx_en", 32'(tx_en), 32'd1);
        req = 4'b0000;
        repeat (16) @(negedge clk);
        check("wdog_err_before_limit", 32'(wdog_err), 32'd0);
        check("wdog_busy_before_limit", 32'(sched_busy), 32'd1);
        @(negedge clk);
`ifdef UART_SCHED_WDOG_EN
        check("wdog_err_at_limit", 32'(wdog_err), 32'd1);
        check("wdog_idle_at_limit", 32'(sched_busy), 32'd0);
        repeat (20) @(negedge clk);
        check("wdog_err_sticky", 32'(wdog_err), 32'd1);
`else
        check("wdog_err_disabled", 32'(wdog_err), 32'd0);
        check("wdog_still_waiting", 32'(sched_busy), 32'd1);
        repeat (20) @(negedge clk);
        check("wdog_err_disabled_later", 32'(wdog_err), 32'd0);
        check("wdog_still_waiting_later", 32'(sched_busy), 32'd1);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("final_rst_wdog_err", 32'(wdog_err), 32'd0);
        check("final_rst_sched_busy", 32'(sched_busy), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_scheduler

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter SIZE, default 8, data width in bits per byte; SHALL match the transmitter's SIZE.
REQ-002 Parameter NUM_REQ, default 4, number of requesters sharing one transmitter; SHALL be at least 2.
REQ-003 Parameter WDOG_CYCLES, default 4096, watchdog limit in clk cycles; SHALL be used only when UART_SCHED_WDOG_EN is defined.
REQ-004 Ports SHALL be as follows; one clock; reset is synchronous and active-high:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- req  input  NUM_REQ  per-requester send request, level.
- req_data  input  NUM_REQ*SIZE  byte of requester i at bits [i*SIZE +: SIZE].
- ack  output  NUM_REQ  one-cycle pulse: requester's byte accepted.
- tx_busy  input  1  transmitter busy flag.
- tx_en  output  1  one-cycle transmit strobe to the transmitter.
- data_in  output  SIZE  byte presented to the transmitter.
- grant_id  output  $clog2(NUM_REQ)  index of the current/last granted requester.
- sched_busy  output  1  high in every state except IDLE.
- wdog_err  output  1  sticky watchdog error flag.

Function
REQ-005 The FSM SHALL have states IDLE, LAUNCH, WAIT_START and WAIT_DONE.
REQ-006 IDLE -> LAUNCH when any req bit is high and tx_busy is low; otherwise the FSM SHALL stay in IDLE.
REQ-007 On the IDLE->LAUNCH edge, the block SHALL register the winner index into grant_id and the winner's byte into data_in.
REQ-008 Winner selection SHALL be round-robin: search starts at (last grant + 1) mod NUM_REQ and takes the first set req bit.
REQ-009 After reset the search SHALL start at requester 0.
REQ-010 In LAUNCH, tx_en and ack[grant_id] SHALL each be high for exactly one cycle, then the FSM SHALL go to WAIT_START.
REQ-011 Latency: req sampled high in IDLE at cycle N SHALL produce tx_en and ack at cycle N+1.
REQ-012 WAIT_START -> WAIT_DONE when tx_busy is high.
REQ-013 WAIT_DONE -> IDLE when tx_busy is low; a new grant SHALL be possible no earlier than the following cycle.
REQ-014 At most one ack bit SHALL be high in any cycle, and tx_en SHALL never be high outside LAUNCH.
REQ-015 data_in and grant_id SHALL remain stable from LAUNCH until the next grant.
REQ-016 A requester SHALL hold req and req_data until ack; a req dropped after the grant SHALL NOT cancel the latched byte.
REQ-017 A requester holding req after its ack SHALL be treated as a new request and SHALL compete in round-robin order.
REQ-018 If tx_busy is high while in IDLE, the block SHALL NOT grant and the round-robin pointer SHALL NOT move.

Reset
REQ-019 With rst high at a clk edge, the FSM SHALL go to IDLE and the pointer to 0.
REQ-020 On reset, tx_en, ack, data_in, grant_id, sched_busy and wdog_err SHALL all be 0.
REQ-021 Reset mid-transfer SHALL abandon the transfer with no further ack or tx_en for it; the transmitter is reset by the same rst.

Configuration
REQ-022 With UART_SCHED_WDOG_EN defined, a counter SHALL run in WAIT_START and WAIT_DONE and SHALL clear on entering either state.
REQ-023 When that counter reaches WDOG_CYCLES, the block SHALL set wdog_err (sticky until rst) and return to IDLE.
REQ-024 Without UART_SCHED_WDOG_EN, the wdog_err port SHALL remain and be tied to 0, no counter SHALL be synthesized, and the FSM SHALL wait indefinitely.

Structure
REQ-025 Package uart_pkg SHALL hold the sched_state_t enum and the default SIZE, NUM_REQ and WDOG_CYCLES constants.
REQ-026 The round-robin selection SHALL be the sub-module rr_arbiter (inputs req and pointer; outputs valid and index).

Verification
REQ-027 Single byte: req=0001, req_data[7:0]=0xA5, tx_busy model high 1 cycle after tx_en for 87 cycles -> one tx_en, data_in=0xA5, ack=0001, return to IDLE.
REQ-028 Fairness: req=1111 held continuously -> grant order 0,1,2,3,0 and exactly one ack per requester per round.
REQ-029 Busy block: tx_busy held high in IDLE with req=0010 -> no grant; tx_busy low -> tx_en the next cycle.
REQ-030 Reset mid-transfer: rst in WAIT_DONE -> all outputs 0 next cycle, no ack; req still high -> requester 0 regranted.
REQ-031 Watchdog (macro defined, WDOG_CYCLES=16): tx_busy never rises -> wdog_err=1 after 16 cycles in WAIT_START, FSM in IDLE; macro undefined -> FSM stays in WAIT_START and wdog_err=0.
